// File: rtl/i2c_regbank_arb.sv
// Owns the single-port register RAM: serializes buffered I2C writes, I2C read
// prefetches and host req/ack accesses, and keeps the prefetched byte coherent.
module i2c_regbank_arb #(
    parameter int ADDR_W        = 8,
    parameter int HOST_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i2c_rw,
    input  logic [7:0]        i2c_addr,
    input  logic              i2c_wen,
    input  logic [7:0]        i2c_wdata,
    input  logic              i2c_rdata_used,
    output logic [7:0]        i2c_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_ack,
    output logic [7:0]        host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              err_ovf
);
    localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1) + 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    typedef enum logic [1:0] {OP_WR, OP_FETCH, OP_HOST} op_t;

    state_t            state, state_nxt;
    op_t               op, op_sel;
    logic              grant;
    logic              host_live;
    logic              host_lose;
    logic              op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [7:0]        op_wdata;

    logic              pend_wr;
    logic [ADDR_W-1:0] wbuf_addr;
    logic [7:0]        wbuf_data;
    logic              wr_clear;

    logic              pend_fetch;
    logic              fvalid;
    logic [ADDR_W-1:0] fetched_addr;
    logic              fetch_busy;
    logic [ADDR_W-1:0] cover_addr;
    logic              cover_ok;
    logic              wr_hit;
    logic              fetch_set;
    logic [ADDR_W-1:0] i2c_addr_t;

    logic [WAIT_W-1:0] wait_cnt;
    logic              unused_inputs;

    assign i2c_addr_t    = i2c_addr[ADDR_W-1:0];
    assign unused_inputs = &{1'b0, i2c_rw, i2c_addr};

    // The ack cycle is already IDLE; masking req there stops a held req from being served twice.
    assign host_live = host_req && !host_ack;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        op_sel    = OP_WR;
        case (state)
            IDLE: begin
                if (host_live && (wait_cnt >= WAIT_MAX)) begin
                    grant  = 1'b1;
                    op_sel = OP_HOST;
                end else if (pend_wr) begin
                    grant  = 1'b1;
                    op_sel = OP_WR;
                end else if (pend_fetch) begin
                    grant  = 1'b1;
                    op_sel = OP_FETCH;
                end else if (host_live) begin
                    grant  = 1'b1;
                    op_sel = OP_HOST;
                end
                if (grant) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign host_lose = host_live && grant && (op_sel != OP_HOST);
    assign wr_clear  = (state == ISSUE) && (op == OP_WR);

    // While a fetch is in flight its address is what the read byte will cover, so
    // compare against it instead of the stale fetched_addr to avoid a redundant refetch.
    assign fetch_busy = (state != IDLE) && (op == OP_FETCH);
    assign cover_addr = fetch_busy ? op_addr : fetched_addr;
    assign cover_ok   = fetch_busy || fvalid;
    assign wr_hit     = (state == ISSUE) && op_we && (op_addr == cover_addr);
    assign fetch_set  = i2c_rdata_used || !cover_ok || (i2c_addr_t != cover_addr) || wr_hit;

    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en && op_we;
    assign mem_addr  = mem_en ? op_addr  : '0;
    assign mem_wdata = mem_en ? op_wdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            op           <= OP_WR;
            op_we        <= 1'b0;
            pend_wr      <= 1'b0;
            err_ovf      <= 1'b0;
            pend_fetch   <= 1'b1;
            fvalid       <= 1'b0;
            fetched_addr <= '0;
            wait_cnt     <= '0;
            host_ack     <= 1'b0;
            host_rdata   <= '0;
            i2c_rdata    <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && grant) begin
                op    <= op_sel;
                op_we <= (op_sel == OP_WR) || ((op_sel == OP_HOST) && host_we);
            end

            // An entry already copied into the op registers this cycle is not an overflow victim.
            if (i2c_wen) begin
                pend_wr <= 1'b1;
                if (pend_wr && !wr_clear) begin
                    err_ovf <= 1'b1;
                end
            end else if (wr_clear) begin
                pend_wr <= 1'b0;
            end

            if (fetch_set) begin
                pend_fetch <= 1'b1;
            end else if ((state == ISSUE) && (op == OP_FETCH)) begin
                pend_fetch <= 1'b0;
            end

            if ((state == IDLE) && grant && (op_sel == OP_HOST)) begin
                wait_cnt <= '0;
            end else if (host_lose && (wait_cnt < WAIT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            host_ack <= (state == DONE) && (op == OP_HOST);
            if (state == DONE) begin
                if (op == OP_FETCH) begin
                    i2c_rdata    <= mem_rdata;
                    fetched_addr <= op_addr;
                    fvalid       <= 1'b1;
                end
                if ((op == OP_HOST) && !op_we) begin
                    host_rdata <= mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i2c_wen) begin
            wbuf_addr <= i2c_addr_t;
            wbuf_data <= i2c_wdata;
        end
        if ((state == IDLE) && grant) begin
            case (op_sel)
                OP_WR: begin
                    op_addr  <= wbuf_addr;
                    op_wdata <= wbuf_data;
                end
                OP_FETCH: begin
                    op_addr  <= i2c_addr_t;
                    op_wdata <= wbuf_data;
                end
                default: begin
                    op_addr  <= host_addr;
                    op_wdata <= host_wdata;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_regbank_arb.sv
// Bench for i2c_regbank_arb: behavioural RAM plus a simple last-write-wins memory
// model; randomized host and I2C traffic checked for data, latency and flags.
module tb_i2c_regbank_arb;
    localparam int ADDR_W  = 8;
    localparam int HMW     = 8;
    localparam int LAT_MAX = 3 * (HMW + 2);

    logic              clk = 1'b0;
    logic              rst;
    logic              i2c_rw;
    logic [7:0]        i2c_addr;
    logic              i2c_wen;
    logic [7:0]        i2c_wdata;
    logic              i2c_rdata_used;
    logic [7:0]        i2c_rdata;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_wdata;
    logic              host_ack;
    logic [7:0]        host_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = 8'h00;
    logic              err_ovf;

    logic [7:0] ram   [256];
    logic [7:0] model [256];
    logic       ram_clr;
    logic       pre_we;
    logic [7:0] pre_addr;
    logic [7:0] pre_data;

    int n_vec = 0;
    int n_err = 0;

    i2c_regbank_arb #(.ADDR_W(ADDR_W), .HOST_MAX_WAIT(HMW)) dut (
        .clk(clk), .rst(rst),
        .i2c_rw(i2c_rw), .i2c_addr(i2c_addr), .i2c_wen(i2c_wen), .i2c_wdata(i2c_wdata),
        .i2c_rdata_used(i2c_rdata_used), .i2c_rdata(i2c_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM, data valid the cycle after mem_en.
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else begin
            if (pre_we) ram[pre_addr] <= pre_data;
            if (mem_en) begin
                if (mem_we) ram[mem_addr] <= mem_wdata;
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        model[a] = d;
        step(1);
        pre_we = 1'b0;
    endtask

    // lat counts steps from driving req to observing ack (uncontended: 3).
    task automatic host_op(input logic we, input logic [7:0] a, input logic [7:0] wd,
                           output logic [7:0] rd, output int lat);
        host_we = we; host_addr = a; host_wdata = wd; host_req = 1'b1;
        lat = 0;
        do begin
            step(1);
            lat++;
        end while (!host_ack && lat < 200);
        if (!host_ack) chk("host_ack_timeout", 32'(host_ack), 32'd1);
        rd = host_rdata;
        host_req = 1'b0;
        if (we) model[a] = wd;
        step(1);
        chk("host_ack_width", 32'(host_ack), 32'd0);
    endtask

    task automatic i2c_write(input logic [7:0] a, input logic [7:0] d);
        i2c_addr = a; i2c_wdata = d; i2c_wen = 1'b1; i2c_rw = 1'b0;
        model[a] = d;
        step(1);
        i2c_wen = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd, rd_a, old30, a, d;
        int lat, lat_a;

        rst = 1'b1; ram_clr = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        i2c_rw = 1'b0; i2c_addr = 8'h00; i2c_wen = 1'b0; i2c_wdata = '0; i2c_rdata_used = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        step(1);
        ram_clr = 1'b0;
        step(1);
        chk("rst_i2c_rdata", 32'(i2c_rdata), 32'h0);
        chk("rst_host_ack", 32'(host_ack), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_err_ovf", 32'(err_ovf), 32'h0);

        preload(8'h00, 8'h5A);
        preload(8'h20, 8'h01);
        preload(8'h21, 8'h02);
        preload(8'h22, 8'h03);
        rst = 1'b0;
        step(4);
        chk("boot_fetch", 32'(i2c_rdata), 32'h5A);
        chk("boot_ovf", 32'(err_ovf), 32'h0);

        host_op(1'b1, 8'h10, 8'h3C, rd, lat);
        chk("hw_latency", 32'(lat), 32'd3);
        host_op(1'b0, 8'h10, 8'h00, rd, lat);
        chk("hr_latency", 32'(lat), 32'd3);
        chk("hr_data", 32'(rd), 32'h3C);

        i2c_addr = 8'h10;
        step(8);
        chk("coh_before", 32'(i2c_rdata), 32'h3C);
        host_op(1'b1, 8'h10, 8'hA5, rd, lat);
        chk("coh_old", 32'(i2c_rdata), 32'h3C);
        step(3);
        chk("coh_new", 32'(i2c_rdata), 32'hA5);

        i2c_addr = 8'h20;
        step(40);
        chk("burst_0", 32'(i2c_rdata), 32'(model[8'h20]));
        for (int k = 1; k < 3; k++) begin
            i2c_rdata_used = 1'b1;
            i2c_addr = 8'h20 + 8'(k);
            step(1);
            i2c_rdata_used = 1'b0;
            step(4);
            chk("burst_next", 32'(i2c_rdata), 32'(model[i2c_addr]));
            step(35);
        end

        fork
            begin
                repeat (30) begin
                    logic [7:0] ha, hd;
                    ha = 8'hC0 | 8'($urandom_range(0, 63));
                    hd = 8'($urandom);
                    if ($urandom_range(0, 1) == 1) begin
                        host_op(1'b1, ha, hd, rd_a, lat_a);
                    end else begin
                        host_op(1'b0, ha, 8'h00, rd_a, lat_a);
                        chk("rand_host_rd", 32'(rd_a), 32'(model[ha]));
                    end
                    chk("rand_host_lat_ok", 32'(lat_a <= LAT_MAX + 1), 32'd1);
                    step($urandom_range(0, 3));
                end
            end
            begin
                repeat (25) begin
                    step($urandom_range(8, 14));
                    i2c_rw = 1'($urandom);
                    if ($urandom_range(0, 2) == 0) begin
                        i2c_rdata_used = 1'b1;
                        i2c_addr = 8'h80 | 8'($urandom_range(0, 63));
                        step(1);
                        i2c_rdata_used = 1'b0;
                    end else begin
                        i2c_write(8'h80 | 8'($urandom_range(0, 63)), 8'($urandom));
                    end
                end
            end
        join
        step(20);
        chk("rand_i2c_rdata", 32'(i2c_rdata), 32'(model[i2c_addr]));
        chk("rand_no_ovf", 32'(err_ovf), 32'h0);
        repeat (6) begin
            a = 8'h80 | 8'($urandom_range(0, 63));
            host_op(1'b0, a, 8'h00, rd, lat);
            chk("rand_readback", 32'(rd), 32'(model[a]));
        end

        old30 = model[8'h30];
        d = 8'($urandom);
        fork
            host_op(1'b1, 8'h40, 8'h77, rd_a, lat_a);
            begin
                step(1);
                i2c_addr = 8'h30; i2c_wdata = 8'h11; i2c_wen = 1'b1;
                step(1);
                i2c_addr = 8'h31; i2c_wdata = d; i2c_wen = 1'b1;
                step(1);
                i2c_wen = 1'b0;
            end
        join
        model[8'h31] = d;
        step(10);
        chk("ovf_set", 32'(err_ovf), 32'h1);
        host_op(1'b0, 8'h30, 8'h00, rd, lat);
        chk("ovf_lost_write", 32'(rd), 32'(old30));
        host_op(1'b0, 8'h31, 8'h00, rd, lat);
        chk("ovf_kept_write", 32'(rd), 32'(d));
        host_op(1'b0, 8'h40, 8'h00, rd, lat);
        chk("ovf_host_write", 32'(rd), 32'h77);
        chk("ovf_sticky", 32'(err_ovf), 32'h1);

        i2c_addr = 8'h50;
        step(10);
        fork
            begin
                step(2);
                host_op(1'b0, 8'hC5, 8'h00, rd_a, lat_a);
                chk("starve_lat_ok", 32'(lat_a <= LAT_MAX + 1), 32'd1);
                chk("starve_rd", 32'(rd_a), 32'(model[8'hC5]));
            end
            begin
                repeat (30) begin
                    i2c_write(8'h50, 8'($urandom));
                    step(2);
                end
            end
        join
        step(20);
        chk("starve_i2c_rdata", 32'(i2c_rdata), 32'(model[8'h50]));

        host_we = 1'b0; host_addr = 8'h31; host_req = 1'b1;
        step(1);
        chk("pre_rst_mem_en", 32'(mem_en), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_abort_mem_en", 32'(mem_en), 32'h0);
        chk("rst_abort_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_abort_ack", 32'(host_ack), 32'h0);
        chk("rst_abort_hrdata", 32'(host_rdata), 32'h0);
        chk("rst_abort_i2c_rdata", 32'(i2c_rdata), 32'h0);
        chk("rst_abort_ovf", 32'(err_ovf), 32'h0);
        host_req = 1'b0;
        step(2);
        rst = 1'b0;
        step(4);
        chk("post_rst_fetch", 32'(i2c_rdata), 32'(model[i2c_addr]));
        chk("post_rst_ack", 32'(host_ack), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_regbank_arb.md
# i2c_regbank_arb

Arbiter and sequencer for the single-port 8-bit register RAM behind the I2C slave application bus. It serves two requesters: the I2C slave side (strobed writes, plus a prefetched read byte that must always be valid for the current I2C address) and a local host port with a req/ack handshake. It owns the RAM port, so it also keeps the prefetched I2C read byte coherent with writes from either side.

## Interface
- ADDR_W, 8, RAM address width; the I2C address bus is 8 bits and is truncated to ADDR_W LSBs.
- HOST_MAX_WAIT, 8, number of IDLE arbitration losses after which the host gets the next slot.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- i2c_rw  in  1  slave transaction direction, informational only
- i2c_addr  in  8  slave application address; the slave increments it itself
- i2c_wen  in  1  one-cycle write strobe
- i2c_wdata  in  8  write data, valid with i2c_wen
- i2c_rdata_used  in  1  one-cycle pulse: slave consumed i2c_rdata and advanced i2c_addr
- i2c_rdata  out  8  prefetched RAM[i2c_addr], registered
- host_req  in  1  level request, held until host_ack
- host_we  in  1  1 = write, 0 = read; stable while host_req is high
- host_addr  in  ADDR_W  host address
- host_wdata  in  8  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  8  read data, valid while host_ack is high, held afterwards
- mem_en, mem_we  out  1  RAM strobe and write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data, valid the cycle after mem_en
- err_ovf  out  1  sticky flag: i2c_wen arrived while an I2C write was still buffered

## Operation
- I2C write buffer: one entry holding address and data, plus a pend_wr flag. i2c_wen loads the buffer and sets pend_wr. If pend_wr is already set, the old entry is overwritten and err_ovf is set.
- Prefetch tracking uses fetched_addr, fvalid and pend_fetch.
  - pend_fetch is set by i2c_rdata_used, by i2c_addr differing from fetched_addr, by fvalid=0, or by any RAM write whose address equals fetched_addr.
  - pend_fetch is cleared when a fetch is issued. A set condition in that same cycle wins.
- FSM states IDLE, ISSUE and DONE; each RAM operation occupies ISSUE and then DONE.
  - IDLE: selects one operation, latches it, and goes to ISSUE. Priority order: pend_wr, then pend_fetch, then host_req. If the wait counter is at least HOST_MAX_WAIT and host_req is high, the host wins instead. With nothing pending, the FSM stays in IDLE.
  - ISSUE: drives mem_en=1 and the latched mem_we, mem_addr and mem_wdata. Clears pend_wr or pend_fetch as appropriate. Goes to DONE.
  - DONE: for a fetch, i2c_rdata <= mem_rdata, fetched_addr <= the latched address, fvalid <= 1. For a host operation, host_ack=1 next cycle and, on a read, host_rdata <= mem_rdata. Goes to IDLE.
- Wait counter: increments (saturating) in each IDLE cycle where host_req is high and the host loses. It clears when the host wins.
- IDLE ignores host_req during the cycle host_ack is high, so a held req is not double-served.
- Same-address writes from both sides are serialized; the later one in grant order wins. A fetch issued after either write returns the updated data.

## Timing
- Reset values: all outputs 0, state IDLE, fvalid=0, pend_fetch=1, pend_wr=0, wait counter 0.
  - The first fetch is issued within 2 cycles of reset release.
- Reset mid-operation aborts the RAM access and clears all state. The host must reissue its request.
- Cycle k means the period after rising edge k.
- Host request (no contention): host_req sampled at edge N in IDLE gives mem_en in cycle N, host_ack and host_rdata in cycle N+2. The next grant is possible at edge N+3.
- i2c_wen at edge N (FSM idle) gives mem_we in cycle N+1. If the written address equals fetched_addr, a refetch follows and the new i2c_rdata appears by cycle N+6.
- i2c_rdata_used at edge N (FSM idle) gives i2c_rdata = RAM[new i2c_addr] by cycle N+4.
  - Worst case with a host operation and an I2C write in flight: cycle N+9. This stays far inside one I2C bit time.
- Maximum host latency from request to ack, under continuous I2C traffic: 3*(HOST_MAX_WAIT+2) cycles.

## Test plan
- Reset, RAM preloaded RAM[0]=0x5A, i2c_addr=0 -> i2c_rdata=0x5A by cycle 4; err_ovf=0.
- Host write 0x3C to 0x10, then host read of 0x10 -> each host_ack is 1 cycle wide, 2 cycles after the sampled req; host_rdata=0x3C.
- i2c_addr=0x10 held, host write 0xA5 to 0x10 -> i2c_rdata changes 0x3C->0xA5 without any I2C strobe.
- Burst: RAM[0x20..0x22]=1,2,3; set i2c_addr=0x20; pulse i2c_rdata_used and increment the address twice, 40 cycles apart -> i2c_rdata sequence 1,2,3.
- i2c_wen twice 1 cycle apart while the FSM is busy with a host operation -> only the second write lands in RAM; err_ovf=1 and stays set until rst.
- Continuous i2c_wen every 3 cycles with host_req held -> host_ack arrives within 3*(HOST_MAX_WAIT+2) cycles; rst asserted in ISSUE -> mem_en=0 immediately and all outputs 0.
